call_stack_ctrl: RTL and testbench
==================================

// Module: call_stack_ctrl
// PURPOSE
//  Return-address stack controller driven by the jump decoder's pushCallStack/popCallStack.
//  Holds predicted return IPs in a DEPTH-entry circular LIFO and supplies the return target for ret.
//  Tracks top pointer and occupancy, and supports flush plus checkpoint restore on mispredict.
//  Sits in the frontend between the jump decoders and the fetch-redirect logic.
// PARAMETERS
//  DEPTH     16  stack entries; power of two, >=4
//  PTR_W     4   log2(DEPTH)
//  IP_WIDTH  48  return-address width
// PORTS
//  clk            in   1         clock
//  rst            in   1         synchronous reset, active-high
//  stall          in   1         hold all state; push/pop ignored
//  pushCallStack  in   1         call decoded: push pushIP
//  pushIP         in   IP_WIDTH  return address (IP of instruction after the call)
//  popCallStack   in   1         ret decoded: pop top entry
//  popIP          out  IP_WIDTH  popped return address (registered)
//  popValid       out  1         popIP valid (registered; 0 on underflow)
//  flush          in   1         empty the stack
//  restore        in   1         reload ptr/count from checkpoint
//  restorePtr     in   PTR_W     checkpoint top pointer
//  restoreCnt     in   PTR_W+1   checkpoint occupancy
//  chkPtr         out  PTR_W     current top pointer, for checkpointing
//  chkCnt         out  PTR_W+1   current occupancy 0..DEPTH
//  empty          out  1         chkCnt==0
// BEHAVIOUR
//  - Reset: ptr=0, cnt=0, popIP=0, popValid=0. Entry RAM is not cleared.
//  - ptr addresses the current top entry. Push writes entry[ptr+1] and sets ptr=ptr+1 (mod DEPTH).
//  - Push: cnt=min(cnt+1,DEPTH). When full, the push silently overwrites the oldest entry.
//  - Pop, cnt>0: next cycle popIP=entry[ptr], popValid=1; ptr=ptr-1 (mod DEPTH); cnt=cnt-1.
//  - Pop, cnt==0 (underflow): next cycle popValid=0, popIP holds its old value; ptr and cnt unchanged.
//  - popValid is a 1-cycle pulse; it deasserts in any cycle with no accepted pop.
//  - Push+pop in the same cycle, cnt>0: popIP=entry[ptr], popValid=1; entry[ptr]=pushIP; ptr and cnt unchanged.
//  - Push+pop in the same cycle, cnt==0: popValid=0; treated as a plain push (cnt=1).
//  - Priority: rst > flush > restore > stall > push/pop.
//  - flush: ptr=0, cnt=0, popValid=0 next cycle; push/pop in that cycle are dropped.
//  - stall: all state held; popValid forced to 0 next cycle.
//  - Pointer arithmetic is PTR_W bits with natural wrap; cnt saturates at 0 and DEPTH.
//  - chkPtr/chkCnt/empty are driven from registered state (pre-update values in the current cycle).
//  - Latency: pop result appears 1 cycle after popCallStack is accepted; a push is visible to a pop in the following cycle.
//  - Back-to-back push then pop, next cycle: the pop returns the just-pushed IP (no bypass needed).
// CONFIGURATION
//  CALLSTACK_RESTORE_EN defined:
//   - restore loads ptr=restorePtr and cnt=min(restoreCnt,DEPTH); popValid=0 next cycle.
//   - Any push/pop in that cycle is dropped.
//  CALLSTACK_RESTORE_EN undefined:
//   - restore behaves exactly as flush (ptr=0, cnt=0).
//   - restorePtr and restoreCnt are ignored.
// TESTING
//  - Reset: rst high 2 cycles -> popValid=0, chkCnt=0, chkPtr=0, empty=1.
//  - LIFO: push 0x1000, 0x2000, 0x3000, then pop x3 -> popIP 0x3000, 0x2000, 0x1000, each popValid=1; then empty=1.
//  - Overflow, DEPTH=16: push IPs 1..17 -> chkCnt=16; 16 pops return 17..2 -> 17th pop gives popValid=0.
//  - Underflow and same-cycle push+pop:
//    - pop on empty -> popValid=0, chkPtr unchanged.
//    - with top=0x40, push 0x80 + pop same cycle -> popIP=0x40, next pop returns 0x80, chkCnt unchanged.
//  - Restore (with CALLSTACK_RESTORE_EN):
//    - save chkPtr/chkCnt after 2 pushes; push 3 more; restore -> chkCnt=2.
//    - the following pop returns the 2nd IP.
//    - without CALLSTACK_RESTORE_EN -> chkCnt=0.
//  - Priority: flush+restore+push asserted together -> chkCnt=0, popValid=0. stall+pop -> state unchanged.

Source files
------------

// File: rtl/call_stack_ctrl.sv
// call_stack_ctrl: return-address stack for the frontend.
// Calls push the IP of the instruction after the call, and rets pop the
// predicted return target. The DEPTH-entry circular LIFO silently overwrites
// its oldest entry when a push arrives while it is full.
// The top pointer and occupancy are exported so that they can be checkpointed
// and restored after a mispredict.
// Optional feature macro: CALLSTACK_RESTORE_EN. When it is undefined, restore
// behaves exactly as flush and the checkpoint inputs are ignored.
//
// Output handshake: popValid/popIP form a registered, valid-only interface with
// no ready. popValid is high for exactly the one cycle after an accepted pop of
// a non-empty stack. popIP holds its last value whenever popValid is low.
module call_stack_ctrl #(
    parameter int DEPTH    = 16,
    parameter int PTR_W    = 4,
    parameter int IP_WIDTH = 48
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                pushCallStack,
    input  logic [IP_WIDTH-1:0] pushIP,
    input  logic                popCallStack,
    output logic [IP_WIDTH-1:0] popIP,
    output logic                popValid,
    input  logic                flush,
    input  logic                restore,
    input  logic [PTR_W-1:0]    restorePtr,
    input  logic [PTR_W:0]      restoreCnt,
    output logic [PTR_W-1:0]    chkPtr,
    output logic [PTR_W:0]      chkCnt,
    output logic                empty
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [IP_WIDTH-1:0] entries [DEPTH];
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W:0]      cnt;

    logic                accept;
    logic                popOk;
    logic                memWe;
    logic [PTR_W-1:0]    memAddr;
    logic [PTR_W-1:0]    ptrNext;
    logic [PTR_W:0]      cntNext;

`ifndef CALLSTACK_RESTORE_EN
    // Checkpoint inputs have no effect in this build.
    logic unusedRestoreInputs;
    assign unusedRestoreInputs = ^{restorePtr, restoreCnt};
`endif

    // Next pointer, next occupancy and entry write decode, in priority order: flush, restore, stall, push/pop.
    always_comb begin
        accept  = !flush && !restore && !stall;
        popOk   = accept && popCallStack && (cnt != '0);
        memWe   = accept && pushCallStack;
        // A push paired with a successful pop replaces the top entry in place.
        memAddr = popOk ? ptr : ptr + 1'b1;
        ptrNext = ptr;
        cntNext = cnt;
        if (flush) begin
            ptrNext = '0;
            cntNext = '0;
        end else if (restore) begin
`ifdef CALLSTACK_RESTORE_EN
            ptrNext = restorePtr;
            cntNext = (restoreCnt > FULL_CNT) ? FULL_CNT : restoreCnt;
`else
            ptrNext = '0;
            cntNext = '0;
`endif
        end else if (stall) begin
            ptrNext = ptr;
            cntNext = cnt;
        end else if (popOk) begin
            if (!pushCallStack) begin
                ptrNext = ptr - 1'b1;
                cntNext = cnt - 1'b1;
            end
        end else if (pushCallStack) begin
            ptrNext = ptr + 1'b1;
            cntNext = (cnt == FULL_CNT) ? FULL_CNT : cnt + 1'b1;
        end
    end

    // Pointer, occupancy and pop result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            cnt      <= '0;
            popIP    <= '0;
            popValid <= 1'b0;
        end else begin
            ptr      <= ptrNext;
            cnt      <= cntNext;
            popValid <= popOk;
            if (popOk) begin
                popIP <= entries[ptr];
            end
        end
    end

    // Entry storage; not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && memWe) begin
            entries[memAddr] <= pushIP;
        end
    end

    assign chkPtr = ptr;
    assign chkCnt = cnt;
    assign empty  = (cnt == '0);

endmodule

// File: tb/tb_call_stack_ctrl.sv
// tb_call_stack_ctrl: drives directed and random traffic into call_stack_ctrl.
// A reference model of the return stack predicts each pop result into a queue.
// A monitor drains that queue whenever popValid is high.
module tb_call_stack_ctrl;

    localparam int DEPTH    = 16;
    localparam int PTR_W    = 4;
    localparam int IP_WIDTH = 48;

    logic                clk = 1'b0;
    logic                rst;
    logic                stall;
    logic                pushCallStack;
    logic [IP_WIDTH-1:0] pushIP;
    logic                popCallStack;
    logic [IP_WIDTH-1:0] popIP;
    logic                popValid;
    logic                flush;
    logic                restore;
    logic [PTR_W-1:0]    restorePtr;
    logic [PTR_W:0]      restoreCnt;
    logic [PTR_W-1:0]    chkPtr;
    logic [PTR_W:0]      chkCnt;
    logic                empty;

    call_stack_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W), .IP_WIDTH(IP_WIDTH)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .pushCallStack(pushCallStack), .pushIP(pushIP),
        .popCallStack(popCallStack), .popIP(popIP), .popValid(popValid),
        .flush(flush), .restore(restore),
        .restorePtr(restorePtr), .restoreCnt(restoreCnt),
        .chkPtr(chkPtr), .chkCnt(chkCnt), .empty(empty)
    );

    // Clock and reset.
    always #5 clk = ~clk;

    // Scoreboard state.
    logic [IP_WIDTH-1:0] expQ[$];
    int nChecks = 0;
    int nPassed = 0;

    // Reference model: a ring of return addresses with a top index and a count.
    logic [IP_WIDTH-1:0] mRing [DEPTH];
    int mTop = 0;
    int mCnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPassed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock of stimulus. The DUT's checkpoint outputs are compared with the
    // model first, and then the model is advanced by the rules for this cycle.
    task automatic drive(input logic pu, input logic [IP_WIDTH-1:0] ip, input logic po,
                         input logic fl, input logic rs, input logic [PTR_W-1:0] rp,
                         input logic [PTR_W:0] rc, input logic st);
        pushCallStack = pu; pushIP = ip; popCallStack = po;
        flush = fl; restore = rs; restorePtr = rp; restoreCnt = rc; stall = st;
        check("chkPtr", 64'(chkPtr), 64'(mTop));
        check("chkCnt", 64'(chkCnt), 64'(mCnt));
        check("empty", 64'(empty), 64'(mCnt == 0));
        if (fl) begin
            mTop = 0; mCnt = 0;
        end else if (rs) begin
`ifdef CALLSTACK_RESTORE_EN
            mTop = int'(rp);
            mCnt = (int'(rc) > DEPTH) ? DEPTH : int'(rc);
`else
            mTop = 0; mCnt = 0;
`endif
        end else if (!st) begin
            if (po && mCnt > 0) begin
                expQ.push_back(mRing[mTop]);
                if (pu) mRing[mTop] = ip;
                else begin
                    mTop = (mTop + DEPTH - 1) % DEPTH;
                    mCnt = mCnt - 1;
                end
            end else if (pu) begin
                mTop = (mTop + 1) % DEPTH;
                mRing[mTop] = ip;
                if (mCnt < DEPTH) mCnt = mCnt + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doPush(input logic [IP_WIDTH-1:0] ip);
        drive(1'b1, ip, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic doPop();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic doIdle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    // Monitor: every valid pop result must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (!rst && popValid) begin
            if (expQ.size() == 0) begin
                check("unexpected_popValid", 64'(popValid), 64'd0);
            end else begin
                check("popIP", 64'(popIP), 64'(expQ.pop_front()));
            end
        end
    end

    logic [PTR_W-1:0] savedPtr;
    logic [PTR_W:0]   savedCnt;

    initial begin
        rst = 1'b1; stall = 1'b0; pushCallStack = 1'b0; pushIP = '0;
        popCallStack = 1'b0; flush = 1'b0; restore = 1'b0;
        restorePtr = '0; restoreCnt = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_popValid", 64'(popValid), 64'd0);
        check("reset_popIP", 64'(popIP), 64'd0);
        check("reset_chkCnt", 64'(chkCnt), 64'd0);
        check("reset_chkPtr", 64'(chkPtr), 64'd0);
        check("reset_empty", 64'(empty), 64'd1);
        rst = 1'b0;

        // Overflow: 17 pushes keep the newest 16, so 16 pops return 17..2.
        for (int i = 1; i <= 17; i++) doPush(IP_WIDTH'(i));
        check("overflow_chkCnt", 64'(chkCnt), 64'd16);
        for (int i = 0; i < 17; i++) doPop();
        doIdle();
        check("after_overflow_empty", 64'(empty), 64'd1);

        // LIFO order.
        doPush(48'h1000); doPush(48'h2000); doPush(48'h3000);
        doPop(); doPop(); doPop();
        doIdle();
        check("lifo_empty", 64'(empty), 64'd1);

        // Pop on an empty stack produces no result and no pointer motion.
        doPop();
        check("underflow_popValid", 64'(popValid), 64'd0);
        doIdle();

        // A push and a pop in the same cycle replace the top entry.
        doPush(48'h40);
        drive(1'b1, 48'h80, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        check("swap_chkCnt", 64'(chkCnt), 64'd1);
        doPop();
        doIdle();

        // Restore a checkpoint that was taken after two pushes.
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        doPush(48'hA1); doPush(48'hA2);
        savedPtr = chkPtr; savedCnt = chkCnt;
        doPush(48'hA3); doPush(48'hA4); doPush(48'hA5);
        drive(1'b1, 48'hFF, 1'b1, 1'b0, 1'b1, savedPtr, savedCnt, 1'b0);
`ifdef CALLSTACK_RESTORE_EN
        check("restore_chkCnt", 64'(chkCnt), 64'd2);
`else
        check("restore_chkCnt", 64'(chkCnt), 64'd0);
`endif
        doPop();
        doIdle();

        // Priority: flush wins over restore and push; stall holds state.
        doPush(48'h55);
        drive(1'b1, 48'h66, 1'b0, 1'b1, 1'b1, 4'd7, 5'd9, 1'b0);
        check("prio_chkCnt", 64'(chkCnt), 64'd0);
        check("prio_popValid", 64'(popValid), 64'd0);
        doPush(48'h77);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
        check("stall_popValid", 64'(popValid), 64'd0);
        check("stall_chkCnt", 64'(chkCnt), 64'd1);

        // Random traffic. Every ring entry has already been written, so any restored window has known contents.
        for (int i = 0; i < 600; i++) begin
            automatic int r = int'($urandom_range(0, 99));
            automatic logic pu = 1'b0, po = 1'b0, fl = 1'b0, rs = 1'b0, st = 1'b0;
            automatic logic [IP_WIDTH-1:0] ip = {16'($urandom), 32'($urandom)};
            if (r < 40) pu = 1'b1;
            else if (r < 75) po = 1'b1;
            else if (r < 85) begin pu = 1'b1; po = 1'b1; end
            else if (r < 88) fl = 1'b1;
            else if (r < 93) rs = 1'b1;
            else if (r < 97) begin st = 1'b1; po = 1'b1; pu = ($urandom_range(0, 1) == 1); end
            if (r % 7 == 0) begin savedPtr = chkPtr; savedCnt = chkCnt; end
            drive(pu, ip, po, fl, rs, savedPtr,
                  ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : savedCnt, st);
        end

        doIdle(); doIdle();
        check("scoreboard_drained", 64'(expQ.size()), 64'd0);
        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
